// File: rtl/mm_pkg.sv
// Shared types for the matrix-multiply result collector: state encoding and lane-index width.
package mm_pkg;
  localparam int ACC_W_DEF = 32;
  localparam int LANE_W = 4;

  typedef logic [LANE_W-1:0] lane_idx_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    WRITE = 3'd2,
    ACK   = 3'd3,
    DONE  = 3'd4
  } mmc_state_e;
endpackage

// File: rtl/mm_rr_arbiter.sv
// Round-robin arbiter: lowest requesting index at/after the pointer wins; the pointer moves
// past the winner only when the grant is accepted.
module mm_rr_arbiter
  import mm_pkg::*;
#(
  parameter int N_DP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_DP-1:0] req_i,
  input  logic            accept_i,
  output logic [N_DP-1:0] grant_o,
  output lane_idx_t       idx_o,
  output logic            valid_o
);
  lane_idx_t ptr_q;
  int        k;

  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    k       = 0;
    for (int i = 0; i < N_DP; i++) begin
      k = (int'(ptr_q) + i) % N_DP;
      if (!valid_o && req_i[k]) begin
        valid_o = 1'b1;
        idx_o   = LANE_W'(k);
      end
    end
    grant_o = valid_o ? (N_DP'(1) << idx_o) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (accept_i && valid_o) begin
      ptr_q <= (idx_o == LANE_W'(N_DP - 1)) ? '0 : idx_o + 1'b1;
    end
  end
endmodule

// File: rtl/mm_result_collector.sv
// Collects one result per dot-product lane per round into the result RAM at base+lane.
// Optional MMC_PERF_CNT_EN adds perf_cycles, counting busy (SCAN/WRITE/ACK) cycles per round.
module mm_result_collector
  import mm_pkg::*;
#(
  parameter int N_DP   = 4,
  parameter int ADDR_W = 8,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [N_DP-1:0]       dp_done,
  input  logic [N_DP*ACC_W-1:0] acc_flat,
  output logic [N_DP-1:0]       ack_ticks,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [ACC_W-1:0]      wr_data,
  output logic                  round_done,
  output logic [N_DP-1:0]       collected,
`ifdef MMC_PERF_CNT_EN
  output logic [31:0]           perf_cycles,
`endif
  output mmc_state_e            dbg_state
);
  mmc_state_e        state_q;
  logic              start_q;
  logic [ADDR_W-1:0] base_q;
  logic [N_DP-1:0]   collected_q;
  logic [N_DP-1:0]   gnt_q;
  logic [N_DP-1:0]   ack_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ACC_W-1:0]  wr_data_q;
  logic              round_done_q;

  logic              start_rise;
  logic [N_DP-1:0]   req;
  logic [N_DP-1:0]   arb_grant;
  lane_idx_t         arb_idx;
  logic              arb_valid;

  assign start_rise = start & ~start_q;
  // Lanes already stored this round are masked so a repeated done is never served twice.
  assign req        = dp_done & ~collected_q;

  mm_rr_arbiter #(.N_DP(N_DP)) u_arb (
    .clk     (clk),
    .rst     (reset),
    .req_i   (req),
    .accept_i(state_q == SCAN),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      base_q       <= '0;
      collected_q  <= '0;
      gnt_q        <= '0;
      ack_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      round_done_q <= 1'b0;
    end else begin
      start_q <= start;
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_rise) begin
            base_q       <= base_addr;
            collected_q  <= '0;
            round_done_q <= 1'b0;
            state_q      <= SCAN;
          end
        end
        SCAN: begin
          if (arb_valid) begin
            gnt_q     <= arb_grant;
            wr_en_q   <= 1'b1;
            wr_addr_q <= base_q + ADDR_W'(arb_idx);
            wr_data_q <= acc_flat[int'(arb_idx)*ACC_W +: ACC_W];
            state_q   <= WRITE;
          end
        end
        WRITE: begin
          collected_q <= collected_q | gnt_q;
          ack_q       <= gnt_q;
          state_q     <= ACK;
        end
        ACK: begin
          if ((dp_done & gnt_q) == '0) begin
            ack_q <= '0;
            if (&collected_q) begin
              round_done_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              state_q <= SCAN;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MMC_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_q <= '0;
    end else if (start_rise && (state_q == IDLE || state_q == DONE)) begin
      perf_q <= '0;
    end else if ((state_q == SCAN || state_q == WRITE || state_q == ACK) && perf_q != 32'hFFFF_FFFF) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

  assign ack_ticks  = ack_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign round_done = round_done_q;
  assign collected  = collected_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_mm_result_collector.sv
// Randomized bench for mm_result_collector: lane driver tasks push expected RAM writes,
// an independent monitor pops and compares them as wr_en/ack_ticks appear.
module tb_mm_result_collector;
  import mm_pkg::*;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic [N-1:0]      dp_done = '0;
  logic [N*DW-1:0]   acc_flat = '0;
  logic [N-1:0]      ack_ticks;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              round_done;
  logic [N-1:0]      collected;
  mmc_state_e        dbg_state;
`ifdef MMC_PERF_CNT_EN
  logic [31:0]       perf_cycles;
`endif

  mm_result_collector #(.N_DP(N), .ADDR_W(AW), .ACC_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .dp_done   (dp_done),
    .acc_flat  (acc_flat),
    .ack_ticks (ack_ticks),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .round_done(round_done),
    .collected (collected),
`ifdef MMC_PERF_CNT_EN
    .perf_cycles(perf_cycles),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard ----------------
  int            n_cmp = 0;
  int            n_err = 0;
  logic [43:0]   exp_q[$];   // {lane[3:0], addr[7:0], data[31:0]}
  logic [43:0]   exp_e;
  int            last_lane = 0;
  int            wr_count = 0;
  logic [N-1:0]  prev_ack = '0;
  logic [N-1:0]  one_hot;
  int            ptr = 0;    // reference round-robin pointer
  int            p1 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
        end else begin
          exp_e = exp_q.pop_front();
          check("wr_addr", 64'(wr_addr), 64'(exp_e[39:32]));
          check("wr_data", 64'(wr_data), 64'(exp_e[31:0]));
          last_lane = int'(exp_e[43:40]);
        end
      end
      if (ack_ticks != '0 && prev_ack == '0) begin
        one_hot = '0;
        one_hot[last_lane] = 1'b1;
        check("ack_lane", 64'(ack_ticks), 64'(one_hot));
      end
      prev_ack = ack_ticks;
    end else begin
      prev_ack = '0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int lane, input logic [AW-1:0] base, input logic [DW-1:0] d);
    logic [3:0]    l4;
    logic [AW-1:0] a;
    l4 = lane[3:0];
    a  = base + AW'(lane);
    exp_q.push_back({l4, a, d});
  endtask

  task automatic wait_ack(input int lane, input logic lvl);
    for (int i = 0; i < 30; i++) begin
      if (ack_ticks[lane] === lvl) return;
      tick();
    end
    n_cmp++;
    n_err++;
    $display("FAIL ack_timeout lane %0d: got %b expected %b", lane, ack_ticks[lane], lvl);
  endtask

  task automatic start_round(input logic [AW-1:0] base);
    base_addr = base;
    start     = 1'b1;
    p1        = cyc + 1;
    wr_count  = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_round();
    int exp_perf;
    for (int i = 0; i < 60; i++) begin
      if (round_done === 1'b1) break;
      tick();
    end
    exp_perf = cyc - p1;
    check("round_done", 64'(round_done), 64'd1);
    check("collected_all", 64'(collected), 64'({N{1'b1}}));
    check("write_count", 64'(wr_count), 64'(N));
    check("state_done", 64'(dbg_state), 64'(DONE));
`ifdef MMC_PERF_CNT_EN
    check("perf_cycles", 64'(perf_cycles), 64'(exp_perf));
    repeat (3) tick();
    check("perf_frozen", 64'(perf_cycles), 64'(exp_perf));
`else
    if (exp_perf < 0) $display("note: negative round length");
`endif
  endtask

  // Lanes finish one at a time in a shuffled order; optionally lane 2 re-raises done after release.
  task automatic seq_round(input logic [AW-1:0] base, input bit fixed, input bit reraise);
    int          order[N];
    int          j, tmp, lane;
    logic [DW-1:0] d;
    for (int i = 0; i < N; i++) order[i] = i;
    if (!fixed) begin
      for (int i = N - 1; i > 0; i--) begin
        j = $urandom_range(i, 0);
        tmp = order[i]; order[i] = order[j]; order[j] = tmp;
      end
    end
    start_round(base);
    for (int i = 0; i < N; i++) begin
      lane = order[i];
      if (fixed) repeat ((i == 0) ? 5 : 1) tick();
      else repeat ($urandom_range(3, 0)) tick();
      d = fixed ? DW'(lane + 1) : DW'($urandom);
      acc_flat[lane*DW +: DW] = d;
      dp_done[lane] = 1'b1;
      push_exp(lane, base, d);
      ptr = (lane + 1) % N;
      wait_ack(lane, 1'b1);
      dp_done[lane] = 1'b0;
      wait_ack(lane, 1'b0);
      if (reraise && lane == 2) dp_done[2] = 1'b1;
    end
    finish_round();
    if (reraise) begin
      check("reraise_no_ack", 64'(ack_ticks[2]), 64'd0);
      dp_done[2] = 1'b0;
    end
    tick();
  endtask

  // All lanes done together; grants expected from the reference pointer onward.
  task automatic sim_round(input logic [AW-1:0] base, input bit mid_start, input bit do_reset);
    logic [DW-1:0] d;
    int            lane;
    start_round(base);
    repeat ($urandom_range(2, 0)) tick();
    for (int l = 0; l < N; l++) begin
      d = DW'($urandom);
      acc_flat[l*DW +: DW] = d;
    end
    for (int i = 0; i < N; i++) begin
      lane = (ptr + i) % N;
      push_exp(lane, base, acc_flat[lane*DW +: DW]);
    end
    dp_done = '1;
    for (int i = 0; i < N; i++) begin
      lane = -1;
      for (int t = 0; t < 30; t++) begin
        if (ack_ticks != '0) break;
        tick();
      end
      for (int l = 0; l < N; l++) if (ack_ticks[l]) lane = l;
      if (lane < 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL grant_timeout: got no ack expected one");
        lane = (ptr + i) % N;
      end
      if (do_reset) begin
        #2 reset = 1'b1;
        #1;
        check("rst_ack", 64'(ack_ticks), 64'd0);
        check("rst_collected", 64'(collected), 64'd0);
        check("rst_round_done", 64'(round_done), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        dp_done = '0;
        exp_q.delete();
        ptr = 0;
        tick();
        reset = 1'b0;
        tick();
        return;
      end
      dp_done[lane] = 1'b0;
      wait_ack(lane, 1'b0);
      if (mid_start && i == 1) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    finish_round();
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", 64'(ack_ticks), 64'd0);
    check("reset_wr_en", 64'(wr_en), 64'd0);
    check("reset_wr_addr", 64'(wr_addr), 64'd0);
    check("reset_wr_data", 64'(wr_data), 64'd0);
    check("reset_round_done", 64'(round_done), 64'd0);
    check("reset_collected", 64'(collected), 64'd0);
    check("reset_state", 64'(dbg_state), 64'(IDLE));
`ifdef MMC_PERF_CNT_EN
    check("reset_perf", 64'(perf_cycles), 64'd0);
`endif
    reset = 1'b0;
    tick();

    seq_round(8'h10, 1'b1, 1'b0);       // in-order lanes, acc 1..4
    sim_round(8'hFE, 1'b0, 1'b0);       // simultaneous, address wrap
    seq_round(AW'($urandom), 1'b0, 1'b1); // lane 2 re-raises after collection
    sim_round(AW'($urandom), 1'b1, 1'b0); // start pulse mid-round ignored
    sim_round(AW'($urandom), 1'b0, 1'b1); // reset while acknowledging
    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(1, 0) == 1) sim_round(AW'($urandom), 1'b0, 1'b0);
      else seq_round(AW'($urandom), 1'b0, 1'b0);
    end

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
